// File: rtl/id_ex_decode.sv
// rtl/id_ex_decode.sv - MIPS instruction decode, ID/EX pipeline register and load-use hazard detect
// Optional DECODE_ILLEGAL_TRAP_EN adds an illegal-instruction flag, a sticky flag and the first illegal PC.
module id_ex_decode #(
   parameter int PC_WIDTH  = 32,
   parameter int IMM_WIDTH = 16,
   parameter int REG_AW    = 5
) (
   input  logic                 d_i_clk,
   input  logic                 d_i_rst,
   input  logic                 d_i_valid,
   input  logic [31:0]          d_i_instr,
   input  logic [PC_WIDTH-1:0]  d_i_pc,
   input  logic                 d_i_stall,
   input  logic                 d_i_flush,
   output logic                 d_o_valid,
   output logic [4:0]           d_o_funct,
   output logic                 d_o_alu_src,
   output logic [IMM_WIDTH-1:0] d_o_imm,
   output logic                 d_o_imm_zext,
   output logic [REG_AW-1:0]    d_o_rs_addr,
   output logic [REG_AW-1:0]    d_o_rt_addr,
   output logic [REG_AW-1:0]    d_o_rd_addr,
   output logic                 d_o_reg_write,
   output logic                 d_o_mem_read,
   output logic                 d_o_mem_write,
   output logic                 d_o_branch,
   output logic                 d_o_jump,
   output logic [25:0]          d_o_jtarget,
   output logic [PC_WIDTH-1:0]  d_o_pc,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic                 d_o_illegal,
   output logic                 d_o_illegal_seen,
   output logic [PC_WIDTH-1:0]  d_o_illegal_pc,
`endif
   output logic                 d_o_hazard_stall
);

   localparam logic [4:0] F_ADD  = 5'd0;
   localparam logic [4:0] F_SUB  = 5'd1;
   localparam logic [4:0] F_AND  = 5'd2;
   localparam logic [4:0] F_OR   = 5'd3;
   localparam logic [4:0] F_NOR  = 5'd4;
   localparam logic [4:0] F_SLT  = 5'd5;
   localparam logic [4:0] F_SLTU = 5'd6;
   localparam logic [4:0] F_SLL  = 5'd7;
   localparam logic [4:0] F_SRL  = 5'd8;
   localparam logic [4:0] F_SRA  = 5'd9;
   localparam logic [4:0] F_EQ   = 5'd10;
   localparam logic [4:0] F_NEQ  = 5'd11;
   localparam logic [4:0] F_ADDU = 5'd14;
   localparam logic [4:0] F_SUBU = 5'd17;
   localparam logic [4:0] F_LUI  = 5'd18;
   localparam logic [4:0] F_JR   = 5'd19;
   localparam logic [4:0] F_ILL  = 5'd31;

   typedef struct packed {
      logic                 valid;
      logic [4:0]           funct;
      logic                 alu_src;
      logic [IMM_WIDTH-1:0] imm;
      logic                 imm_zext;
      logic [REG_AW-1:0]    rs;
      logic [REG_AW-1:0]    rt;
      logic [REG_AW-1:0]    rd;
      logic                 reg_write;
      logic                 mem_read;
      logic                 mem_write;
      logic                 branch;
      logic                 jump;
      logic [25:0]          jtarget;
      logic [PC_WIDTH-1:0]  pc;
   } idex_t;

   idex_t             dec;
   idex_t             nxt;
   idex_t             q;
   logic              dec_legal;
   logic [5:0]        opcode;
   logic [5:0]        fn;
   logic [4:0]        shamt;
   logic [4:0]        shift_code;
   logic [REG_AW-1:0] f_rs;
   logic [REG_AW-1:0] f_rt;
   logic [REG_AW-1:0] f_rd;
   logic              src1_match;
   logic              src2_match;

   assign opcode = d_i_instr[31:26];
   assign fn     = d_i_instr[5:0];
   assign shamt  = d_i_instr[10:6];
   assign f_rs   = REG_AW'(d_i_instr[25:21]);
   assign f_rt   = REG_AW'(d_i_instr[20:16]);
   assign f_rd   = REG_AW'(d_i_instr[15:11]);

   // funct[1:0] selects the shift kind for both the shamt and variable forms
   assign shift_code = (fn[1:0] == 2'b00) ? F_SLL : (fn[0] ? F_SRA : F_SRL);

   always_comb begin
      dec       = '0;
      dec_legal = 1'b1;
      dec.valid = d_i_valid;
      dec.pc    = d_i_pc;
      dec.rs    = f_rs;
      dec.rt    = f_rt;
      dec.imm   = IMM_WIDTH'(d_i_instr[15:0]);
      case (opcode)
         6'h00: begin
            dec.rd        = f_rd;
            dec.reg_write = 1'b1;
            dec.imm       = '0;
            case (fn)
               6'h20: dec.funct = F_ADD;
               6'h21: dec.funct = F_ADDU;
               6'h22: dec.funct = F_SUB;
               6'h23: dec.funct = F_SUBU;
               6'h24: dec.funct = F_AND;
               6'h25: dec.funct = F_OR;
               6'h27: dec.funct = F_NOR;
               6'h2A: dec.funct = F_SLT;
               6'h2B: dec.funct = F_SLTU;
               6'h00, 6'h02, 6'h03: begin
                  dec.funct   = shift_code;
                  dec.rs      = f_rt;
                  dec.alu_src = 1'b1;
                  dec.imm     = IMM_WIDTH'(shamt);
               end
               6'h04, 6'h06, 6'h07: begin
                  // the value being shifted travels as operand 1, the amount as operand 2
                  dec.funct = shift_code;
                  dec.rs    = f_rt;
                  dec.rt    = f_rs;
               end
               6'h08: begin
                  dec.funct     = F_JR;
                  dec.reg_write = 1'b0;
               end
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23: begin
            dec.alu_src   = 1'b1;
            dec.rd        = f_rt;
            dec.reg_write = 1'b1;
            dec.mem_read  = (opcode == 6'h23);
            dec.imm_zext  = (opcode == 6'h0C) || (opcode == 6'h0D);
            case (opcode)
               6'h09:   dec.funct = F_ADDU;
               6'h0A:   dec.funct = F_SLT;
               6'h0B:   dec.funct = F_SLTU;
               6'h0C:   dec.funct = F_AND;
               6'h0D:   dec.funct = F_OR;
               6'h0F:   dec.funct = F_LUI;
               default: dec.funct = F_ADD;
            endcase
         end
         6'h2B: begin
            dec.funct     = F_ADD;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         6'h04, 6'h05: begin
            dec.funct  = opcode[0] ? F_NEQ : F_EQ;
            dec.branch = 1'b1;
         end
         6'h02: begin
            dec.rs      = '0;
            dec.rt      = '0;
            dec.imm     = '0;
            dec.jump    = 1'b1;
            dec.jtarget = d_i_instr[25:0];
         end
         default: dec_legal = 1'b0;
      endcase
      if (!dec_legal) begin
         dec       = '0;
         dec.funct = F_ILL;
         dec.valid = d_i_valid;
         dec.pc    = d_i_pc;
      end
      // writes to $0 are dropped so the all-zero NOP is side-effect free
      if (dec.rd == '0) begin
         dec.reg_write = 1'b0;
      end
   end

   assign src1_match = (dec.rs == q.rd);
   assign src2_match = (!dec.alu_src || dec.mem_write) && (dec.rt == q.rd);
   assign d_o_hazard_stall = d_i_valid && q.valid && q.mem_read && (q.rd != '0) &&
                             (src1_match || src2_match);

   always_comb begin
      nxt = dec;
      if (!d_i_valid) begin
         nxt.reg_write = 1'b0;
         nxt.mem_read  = 1'b0;
         nxt.mem_write = 1'b0;
         nxt.branch    = 1'b0;
         nxt.jump      = 1'b0;
      end
      if (d_i_flush || d_o_hazard_stall) begin
         nxt = '0;
      end
   end

   // flush overrides stall; a hazard bubble is folded into nxt
   always_ff @(posedge d_i_clk or posedge d_i_rst) begin
      if (d_i_rst) begin
         q <= '0;
      end else if (d_i_flush || !d_i_stall) begin
         q <= nxt;
      end
   end

   assign d_o_valid     = q.valid;
   assign d_o_funct     = q.funct;
   assign d_o_alu_src   = q.alu_src;
   assign d_o_imm       = q.imm;
   assign d_o_imm_zext  = q.imm_zext;
   assign d_o_rs_addr   = q.rs;
   assign d_o_rt_addr   = q.rt;
   assign d_o_rd_addr   = q.rd;
   assign d_o_reg_write = q.reg_write;
   assign d_o_mem_read  = q.mem_read;
   assign d_o_mem_write = q.mem_write;
   assign d_o_branch    = q.branch;
   assign d_o_jump      = q.jump;
   assign d_o_jtarget   = q.jtarget;
   assign d_o_pc        = q.pc;

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic                ill_q;
   logic                ill_seen_q;
   logic [PC_WIDTH-1:0] ill_pc_q;
   logic                load_en;
   logic                ill_load;

   assign load_en  = !d_i_flush && !d_i_stall && !d_o_hazard_stall;
   assign ill_load = load_en && d_i_valid && !dec_legal;

   always_ff @(posedge d_i_clk or posedge d_i_rst) begin
      if (d_i_rst) begin
         ill_q      <= 1'b0;
         ill_seen_q <= 1'b0;
         ill_pc_q   <= '0;
      end else begin
         if (d_i_flush || !d_i_stall) begin
            ill_q <= ill_load;
         end
         if (ill_load && !ill_seen_q) begin
            ill_seen_q <= 1'b1;
            ill_pc_q   <= d_i_pc;
         end
      end
   end

   assign d_o_illegal      = ill_q;
   assign d_o_illegal_seen = ill_seen_q;
   assign d_o_illegal_pc   = ill_pc_q;
`endif

endmodule

// File: tb/tb_id_ex_decode.sv
// tb/tb_id_ex_decode.sv - self-checking bench for id_ex_decode
// Directed scenarios plus randomized instruction streams against a behavioural model.
module tb_id_ex_decode;

   logic        clk;
   logic        rst;
   logic        vin;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        stall;
   logic        flush;

   logic        d_o_valid;
   logic [4:0]  d_o_funct;
   logic        d_o_alu_src;
   logic [15:0] d_o_imm;
   logic        d_o_imm_zext;
   logic [4:0]  d_o_rs_addr;
   logic [4:0]  d_o_rt_addr;
   logic [4:0]  d_o_rd_addr;
   logic        d_o_reg_write;
   logic        d_o_mem_read;
   logic        d_o_mem_write;
   logic        d_o_branch;
   logic        d_o_jump;
   logic [25:0] d_o_jtarget;
   logic [31:0] d_o_pc;
   logic        d_o_hazard_stall;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        d_o_illegal;
   logic        d_o_illegal_seen;
   logic [31:0] d_o_illegal_pc;
`endif

   typedef struct packed {
      logic        valid;
      logic [4:0]  funct;
      logic        alu_src;
      logic [15:0] imm;
      logic        imm_zext;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic [25:0] jtarget;
      logic [31:0] pc;
   } out_t;

   out_t dut_o;
   assign dut_o = {d_o_valid, d_o_funct, d_o_alu_src, d_o_imm, d_o_imm_zext, d_o_rs_addr,
                   d_o_rt_addr, d_o_rd_addr, d_o_reg_write, d_o_mem_read, d_o_mem_write,
                   d_o_branch, d_o_jump, d_o_jtarget, d_o_pc};

   // kinds: 0-8 R alu, 9-11 shamt shifts, 12-14 variable shifts, 15 jr, 16-22 I alu,
   // 23 lw, 24 sw, 25 beq, 26 bne, 27 j, 28 illegal
   localparam logic [5:0] K_CODE [0:28] = '{
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F,
      6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
   localparam logic [4:0] K_ALU [0:28] = '{
      5'd0, 5'd14, 5'd1, 5'd17, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
      5'd7, 5'd8, 5'd9, 5'd7, 5'd8, 5'd9, 5'd19,
      5'd0, 5'd14, 5'd5, 5'd6, 5'd2, 5'd3, 5'd18,
      5'd0, 5'd0, 5'd10, 5'd11, 5'd0, 5'd31};

   int checks;
   int errors;

   id_ex_decode dut (
      .d_i_clk          (clk),
      .d_i_rst          (rst),
      .d_i_valid        (vin),
      .d_i_instr        (instr),
      .d_i_pc           (pc),
      .d_i_stall        (stall),
      .d_i_flush        (flush),
      .d_o_valid        (d_o_valid),
      .d_o_funct        (d_o_funct),
      .d_o_alu_src      (d_o_alu_src),
      .d_o_imm          (d_o_imm),
      .d_o_imm_zext     (d_o_imm_zext),
      .d_o_rs_addr      (d_o_rs_addr),
      .d_o_rt_addr      (d_o_rt_addr),
      .d_o_rd_addr      (d_o_rd_addr),
      .d_o_reg_write    (d_o_reg_write),
      .d_o_mem_read     (d_o_mem_read),
      .d_o_mem_write    (d_o_mem_write),
      .d_o_branch       (d_o_branch),
      .d_o_jump         (d_o_jump),
      .d_o_jtarget      (d_o_jtarget),
      .d_o_pc           (d_o_pc),
`ifdef DECODE_ILLEGAL_TRAP_EN
      .d_o_illegal      (d_o_illegal),
      .d_o_illegal_seen (d_o_illegal_seen),
      .d_o_illegal_pc   (d_o_illegal_pc),
`endif
      .d_o_hazard_stall (d_o_hazard_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [15:0] imm, input logic [25:0] tgt,
                                       input bit alt);
      logic [31:0] w;
      if (k <= 15)
         w = {6'h00, rs, rt, rd, ((k >= 9 && k <= 11) ? sh : 5'd0), K_CODE[k]};
      else if (k <= 26)
         w = {K_CODE[k], rs, rt, imm};
      else if (k == 27)
         w = {6'h02, tgt};
      else
         w = alt ? {6'h00, tgt[19:0], 6'h01} : {6'h3F, tgt};
      return w;
   endfunction

   function automatic out_t ref_expect(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [15:0] imm, input logic [25:0] tgt,
                                       input logic [31:0] p);
      out_t e;
      e = '0;
      e.valid = 1'b1;
      e.pc    = p;
      e.funct = K_ALU[k];
      if (k <= 8) begin
         e.rs = rs; e.rt = rt; e.rd = rd; e.reg_write = 1'b1;
      end else if (k <= 11) begin
         e.rs = rt; e.rt = rt; e.rd = rd; e.alu_src = 1'b1; e.imm = {11'b0, sh}; e.reg_write = 1'b1;
      end else if (k <= 14) begin
         e.rs = rt; e.rt = rs; e.rd = rd; e.reg_write = 1'b1;
      end else if (k == 15) begin
         e.rs = rs; e.rt = rt; e.rd = rd;
      end else if (k <= 23) begin
         e.rs = rs; e.rt = rt; e.rd = rt; e.alu_src = 1'b1; e.imm = imm; e.reg_write = 1'b1;
         e.imm_zext = (k == 20) || (k == 21);
         e.mem_read = (k == 23);
      end else if (k == 24) begin
         e.rs = rs; e.rt = rt; e.alu_src = 1'b1; e.imm = imm; e.mem_write = 1'b1;
      end else if (k <= 26) begin
         e.rs = rs; e.rt = rt; e.imm = imm; e.branch = 1'b1;
      end else if (k == 27) begin
         e.jump = 1'b1; e.jtarget = tgt;
      end
      if (e.rd == 5'd0) e.reg_write = 1'b0;
      return e;
   endfunction

   task automatic issue(input logic [31:0] ins, input logic [31:0] p);
      @(negedge clk);
      instr = ins; pc = p; vin = 1'b1; stall = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      vin = 1'b1; instr = 32'h00221820;
      #2;
      checks++;
      if (dut_o !== '0 || d_o_hazard_stall !== 1'b0) begin
         errors++; $display("FAIL reset_initial got %h want 0", dut_o);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (d_o_valid !== 1'b1) begin
         errors++; $display("FAIL reset_preload valid got %b want 1", d_o_valid);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dut_o !== '0) begin
         errors++; $display("FAIL reset_async got %h want 0", dut_o);
      end
      @(negedge clk); rst = 1'b0; vin = 1'b0;
   endtask

   task automatic test_add();
      issue(32'h00221820, 32'h0000_0040);
      checks++;
      if ({d_o_valid, d_o_funct, d_o_alu_src, d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_reg_write, d_o_pc}
          !== {1'b1, 5'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h40}) begin
         errors++;
         $display("FAIL add got funct=%0d src=%b rs=%0d rt=%0d rd=%0d wr=%b want 0 0 1 2 3 1",
                  d_o_funct, d_o_alu_src, d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_reg_write);
      end
   endtask

   task automatic test_shift();
      issue(32'h000521C0, 32'h0000_0044);
      checks++;
      if ({d_o_funct, d_o_rs_addr, d_o_alu_src, d_o_imm, d_o_rd_addr, d_o_reg_write}
          !== {5'd7, 5'd5, 1'b1, 16'h0007, 5'd4, 1'b1}) begin
         errors++;
         $display("FAIL sll got funct=%0d rs=%0d src=%b imm=%h rd=%0d want 7 5 1 0007 4",
                  d_o_funct, d_o_rs_addr, d_o_alu_src, d_o_imm, d_o_rd_addr);
      end
   endtask

   task automatic test_imm();
      issue(32'h34068001, 32'h0000_0048);
      checks++;
      if ({d_o_funct, d_o_imm, d_o_imm_zext, d_o_rd_addr, d_o_alu_src, d_o_reg_write}
          !== {5'd3, 16'h8001, 1'b1, 5'd6, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL ori got funct=%0d imm=%h zext=%b rd=%0d want 3 8001 1 6",
                  d_o_funct, d_o_imm, d_o_imm_zext, d_o_rd_addr);
      end
      issue(32'h3C071234, 32'h0000_004C);
      checks++;
      if ({d_o_funct, d_o_imm, d_o_imm_zext, d_o_rd_addr} !== {5'd18, 16'h1234, 1'b0, 5'd7}) begin
         errors++;
         $display("FAIL lui got funct=%0d imm=%h zext=%b rd=%0d want 18 1234 0 7",
                  d_o_funct, d_o_imm, d_o_imm_zext, d_o_rd_addr);
      end
   endtask

   task automatic test_load_use();
      issue(32'h8D280000, 32'h0000_0050);
      checks++;
      if ({d_o_valid, d_o_mem_read, d_o_rd_addr, d_o_reg_write, d_o_rs_addr} !== {1'b1, 1'b1, 5'd8, 1'b1, 5'd9}) begin
         errors++; $display("FAIL lw got mr=%b rd=%0d wr=%b want 1 8 1", d_o_mem_read, d_o_rd_addr, d_o_reg_write);
      end
      @(negedge clk);
      instr = 32'h01015020; pc = 32'h0000_0054;
      #1;
      checks++;
      if (d_o_hazard_stall !== 1'b1) begin
         errors++; $display("FAIL hazard_raise got %b want 1", d_o_hazard_stall);
      end
      @(posedge clk); #1;
      checks++;
      if (dut_o !== '0) begin
         errors++; $display("FAIL hazard_bubble got %h want 0", dut_o);
      end
      checks++;
      if (d_o_hazard_stall !== 1'b0) begin
         errors++; $display("FAIL hazard_drop got %b want 0", d_o_hazard_stall);
      end
      @(posedge clk); #1;
      checks++;
      if ({d_o_valid, d_o_funct, d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_reg_write}
          !== {1'b1, 5'd0, 5'd8, 5'd1, 5'd10, 1'b1}) begin
         errors++; $display("FAIL hazard_reload got valid=%b funct=%0d rs=%0d want 1 0 8", d_o_valid, d_o_funct, d_o_rs_addr);
      end
   endtask

   task automatic test_flush_stall();
      issue(32'h00221820, 32'h0000_0100);
      @(negedge clk);
      instr = 32'h10220004; pc = 32'h0000_0104; flush = 1'b1; stall = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut_o !== '0) begin
         errors++; $display("FAIL flush_over_stall got %h want 0", dut_o);
      end
      issue(32'h00221820, 32'h0000_0108);
      @(negedge clk);
      instr = 32'h3C071234; pc = 32'h0000_010C; stall = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({d_o_valid, d_o_funct, d_o_rd_addr, d_o_imm, d_o_pc} !== {1'b1, 5'd0, 5'd3, 16'h0, 32'h108}) begin
         errors++; $display("FAIL stall_hold got funct=%0d rd=%0d pc=%h want 0 3 108", d_o_funct, d_o_rd_addr, d_o_pc);
      end
      @(negedge clk); stall = 1'b0;
   endtask

   task automatic test_illegal();
      issue(32'hFC000000, 32'h0000_0ABC);
      checks++;
      if ({d_o_valid, d_o_funct, d_o_alu_src, d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_branch, d_o_jump}
          !== {1'b1, 5'd31, 6'b0}) begin
         errors++; $display("FAIL illegal got valid=%b funct=%0d want 1 31 controls 0", d_o_valid, d_o_funct);
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      checks++;
      if ({d_o_illegal, d_o_illegal_seen, d_o_illegal_pc} !== {1'b1, 1'b1, 32'h0ABC}) begin
         errors++; $display("FAIL illegal_trap got %b %b %h want 1 1 00000abc", d_o_illegal, d_o_illegal_seen, d_o_illegal_pc);
      end
      issue(32'hFC000000, 32'h0000_0DEF);
      checks++;
      if (d_o_illegal_pc !== 32'h0ABC) begin
         errors++; $display("FAIL illegal_pc_once got %h want 00000abc", d_o_illegal_pc);
      end
`endif
   endtask

   task automatic test_random();
      out_t st;
      out_t dec;
      out_t nx;
      bit   hz;
      @(negedge clk); rst = 1'b1; vin = 1'b0; stall = 1'b0; flush = 1'b0;
      @(negedge clk); rst = 1'b0;
      st = '0;
      for (int n = 0; n < 800; n++) begin
         int          k;
         logic [4:0]  rs_f, rt_f, rd_f, sh_f;
         logic [15:0] imm_f;
         logic [25:0] tgt_f;
         bit          alt;
         @(negedge clk);
         k     = ($urandom_range(0, 9) < 3) ? 23 : int'($urandom_range(0, 28));
         rs_f  = 5'($urandom_range(0, 3));
         rt_f  = 5'($urandom_range(0, 3));
         rd_f  = 5'($urandom_range(0, 3));
         sh_f  = 5'($urandom);
         imm_f = 16'($urandom);
         tgt_f = 26'($urandom);
         alt   = 1'($urandom);
         instr = enc(k, rs_f, rt_f, rd_f, sh_f, imm_f, tgt_f, alt);
         pc    = $urandom;
         vin   = ($urandom_range(0, 7) != 0);
         flush = ($urandom_range(0, 15) == 0);
         stall = ($urandom_range(0, 9) == 0);
         dec   = ref_expect(k, rs_f, rt_f, rd_f, sh_f, imm_f, tgt_f, pc);
         hz    = vin && st.valid && st.mem_read && (st.rd != 5'd0) &&
                 ((dec.rs == st.rd) || ((!dec.alu_src || dec.mem_write) && (dec.rt == st.rd)));
         #1;
         checks++;
         if (d_o_hazard_stall !== hz) begin
            errors++; $display("FAIL rand_hazard n=%0d instr=%h got %b want %b", n, instr, d_o_hazard_stall, hz);
         end
         nx = dec;
         nx.valid = vin;
         if (!vin) begin
            nx.reg_write = 1'b0; nx.mem_read = 1'b0; nx.mem_write = 1'b0; nx.branch = 1'b0; nx.jump = 1'b0;
         end
         if (flush)      nx = '0;
         else if (stall) nx = st;
         else if (hz)    nx = '0;
         @(posedge clk);
         st = nx;
         #1;
         checks++;
         if (dut_o !== st) begin
            errors++; $display("FAIL rand_idex n=%0d instr=%h got %h want %h", n, instr, dut_o, st);
         end
      end
      @(negedge clk); vin = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; vin = 1'b0; instr = '0; pc = '0; stall = 1'b0; flush = 1'b0;
      test_reset();
      test_add();
      test_shift();
      test_imm();
      test_load_use();
      test_flush_stall();
      test_illegal();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
